// File: rtl/router_ctrl_if.sv
// Router control-plane signal bundle.
// master drives packet/FIFO status; slave is the controller.
interface router_ctrl_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] rd_en;
  logic [2:0] wr_en;
  logic       fifo_full_sel;
  logic [2:0] vld_out;
  logic [2:0] soft_rst;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;

  modport master (
    output pkt_valid, data_in, parity_done, low_pkt_valid,
    output fifo_full, fifo_empty, rd_en,
    input  wr_en, fifo_full_sel, vld_out, soft_rst,
    input  detect_add, lfd_state, ld_state, laf_state,
    input  full_state, rst_int_reg, write_enb_reg, busy
  );

  modport slave (
    input  pkt_valid, data_in, parity_done, low_pkt_valid,
    input  fifo_full, fifo_empty, rd_en,
    output wr_en, fifo_full_sel, vld_out, soft_rst,
    output detect_add, lfd_state, ld_state, laf_state,
    output full_state, rst_int_reg, write_enb_reg, busy
  );
endinterface

// File: rtl/router_ctrl.sv
// 1x3 router control plane: packet-write FSM,
// destination decode and per-port read timeout.
module router_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input logic          clk,
  input logic          rstn,
  router_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_DECODE,
    S_WAIT,
    S_LFD,
    S_LD,
    S_FULL,
    S_LAF,
    S_LP,
    S_CPE
  } state_e;

  state_e                      state_q, state_d;
  logic [1:0]                  addr_q, addr_d;
  logic [2:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]                  soft_q, soft_d;
  logic [1:0]                  sel_idx;
  logic [2:0]                  sel_oh;
  logic [2:0]                  addr_oh;
  logic                        sel_empty;
  logic                        sel_full;
  logic                        detect;
  logic [2:0]                  vld;

  assign detect = (state_q == S_DECODE);
  assign vld    = ~bus.fifo_empty;

  // Header byte selects the FIFO before addr_q has captured it.
  always_comb begin
    sel_idx = detect ? bus.data_in[1:0] : addr_q;
    case (sel_idx)
      2'd0:    sel_oh = 3'b001;
      2'd1:    sel_oh = 3'b010;
      2'd2:    sel_oh = 3'b100;
      default: sel_oh = 3'b000;
    endcase
    case (addr_q)
      2'd0:    addr_oh = 3'b001;
      2'd1:    addr_oh = 3'b010;
      2'd2:    addr_oh = 3'b100;
      default: addr_oh = 3'b000;
    endcase
    sel_empty = |(sel_oh & bus.fifo_empty);
    sel_full  = |(sel_oh & bus.fifo_full);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_DECODE:
        if (bus.pkt_valid && bus.data_in[1:0] != 2'd3)
          state_d = sel_empty ? S_LFD : S_WAIT;
      S_WAIT:
        if (sel_empty) state_d = S_LFD;
      S_LFD:
        state_d = S_LD;
      S_LD:
        if (sel_full)            state_d = S_FULL;
        else if (!bus.pkt_valid) state_d = S_LP;
      S_FULL:
        if (!sel_full) state_d = S_LAF;
      S_LAF:
        if (bus.parity_done)        state_d = S_DECODE;
        else if (bus.low_pkt_valid) state_d = S_LP;
        else                        state_d = S_LD;
      S_LP:
        state_d = S_CPE;
      S_CPE:
        state_d = sel_full ? S_FULL : S_DECODE;
      default:
        state_d = S_DECODE;
    endcase
    // Stalled reader on our port abandons the packet.
    if (|(addr_oh & soft_q)) state_d = S_DECODE;
  end

  always_comb begin
    addr_d = addr_q;
    if (detect && bus.pkt_valid) addr_d = bus.data_in[1:0];
  end

  always_comb begin
    cnt_d  = cnt_q;
    soft_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (bus.rd_en[i] || !vld[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(TIMEOUT - 1)) begin
        cnt_d[i]  = '0;
        soft_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_DECODE;
      addr_q  <= '0;
      cnt_q   <= '0;
      soft_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      soft_q  <= soft_d;
    end
  end

  always_comb begin
    bus.detect_add    = detect;
    bus.lfd_state     = (state_q == S_LFD);
    bus.ld_state      = (state_q == S_LD);
    bus.laf_state     = (state_q == S_LAF);
    bus.full_state    = (state_q == S_FULL);
    bus.rst_int_reg   = (state_q == S_CPE);
    bus.write_enb_reg = (state_q == S_LD) || (state_q == S_LAF) ||
                        (state_q == S_LP);
    bus.busy          = (state_q == S_WAIT) || (state_q == S_LFD) ||
                        (state_q == S_FULL) || (state_q == S_LAF) ||
                        (state_q == S_LP)   || (state_q == S_CPE);
    bus.wr_en         = {3{bus.write_enb_reg}} & addr_oh;
    bus.fifo_full_sel = |(addr_oh & bus.fifo_full);
    bus.vld_out       = vld;
    bus.soft_rst      = soft_q;
  end

endmodule
